// File: rtl/spi_conf_regs.sv
// spi_conf_regs: oversampled SPI command decoder feeding a register bank, with guarded major-mode changes
module spi_conf_regs #(
    parameter int CMD_W  = 16,
    parameter int OP_W   = 4,
    parameter int DATA_W = 8,
    parameter int NREG   = 4,
    parameter int MODE_W = 3,
    parameter int GUARD  = 8,
    parameter int SYNC   = 2
) (
    input  logic                     ck_1356meg,
    input  logic                     nrst,
    input  logic                     spck,
    input  logic                     ncs,
    input  logic                     mosi,
    output logic                     miso,
    output logic [NREG*DATA_W-1:0]   regs,
    output logic [MODE_W-1:0]        major_mode,
    output logic                     mode_busy,
    output logic                     cmd_strobe,
    output logic                     cmd_err
);
    localparam int CW = $clog2(CMD_W + 2);
    localparam int GW = $clog2(GUARD + 1);
    localparam int IW = NREG > 1 ? $clog2(NREG) : 1;
    localparam logic [MODE_W-1:0] OFF = '1;
    localparam logic [OP_W-1:0] OP_RD = '1;
    localparam logic [DATA_W-1:0] R0_RST = DATA_W'(OFF) << (DATA_W - MODE_W);
    typedef enum logic {IDLE, GUARD_ST} state_t;
    state_t state, state_nx;
    logic [SYNC-1:0] spck_s, ncs_s, mosi_s;
    logic spck_d, ncs_d, frame_end;
    logic spck_y, ncs_y, mosi_y, spck_rise, spck_fall, ncs_rise, ncs_fall;
    logic [CMD_W-1:0] sr, rb;
    logic [CW-1:0] bcnt;
    logic [NREG-1:0][DATA_W-1:0] r;
    logic [DATA_W-1:0] pend, pend_nx, reg0_nx, dat;
    logic [MODE_W-1:0] mode_nx, dmode;
    logic [GW-1:0] gcnt, gcnt_nx;
    logic [OP_W-1:0] op;
    logic [IW-1:0] idx, rd_src;
    logic rd_v, len_ok, is_wr, rd_ok, ok, wr0, unused_bits;
    assign spck_y = spck_s[SYNC-1];
    assign ncs_y = ncs_s[SYNC-1];
    assign mosi_y = mosi_s[SYNC-1];
    assign spck_rise = spck_y & ~spck_d;
    assign spck_fall = ~spck_y & spck_d;
    assign ncs_rise = ncs_y & ~ncs_d;
    assign ncs_fall = ~ncs_y & ncs_d;
    assign op = sr[CMD_W-1 -: OP_W];
    assign dat = sr[DATA_W-1:0];
    assign dmode = dat[DATA_W-1 -: MODE_W];
    assign idx = dat[IW-1:0];
    assign unused_bits = ^sr;
    assign len_ok = bcnt == CW'(CMD_W);
    assign is_wr = op != '0 && op <= OP_W'(NREG);
    assign rd_ok = op == OP_RD && {1'b0, idx} < (IW + 1)'(NREG);
    assign ok = frame_end && len_ok && (op == '0 || is_wr || rd_ok);
    assign wr0 = ok && op == OP_W'(1);
    assign regs = r;
    assign miso = rb[CMD_W-1];
    assign mode_busy = state == GUARD_ST;
    // a write naming the live mode, or the all-off mode, bypasses the guard window
    always_comb begin
        state_nx = state;
        reg0_nx = r[0];
        mode_nx = major_mode;
        pend_nx = pend;
        gcnt_nx = gcnt;
        if (wr0 && (dmode == OFF || (state == IDLE && dmode == major_mode))) begin
            reg0_nx = dat;
            mode_nx = dmode;
            state_nx = IDLE;
        end else if (wr0) begin
            pend_nx = dat;
            mode_nx = OFF;
            gcnt_nx = GW'(GUARD);
            state_nx = GUARD_ST;
        end else if (state == GUARD_ST) begin
            gcnt_nx = gcnt - 1'b1;
            if (gcnt == GW'(1)) begin
                reg0_nx = pend;
                mode_nx = pend[DATA_W-1 -: MODE_W];
                state_nx = IDLE;
            end
        end
    end
    // chip select idles high so releasing reset does not look like a frame end
    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            spck_s <= '0;
            ncs_s <= '1;
            mosi_s <= '0;
            spck_d <= 1'b0;
            ncs_d <= 1'b1;
            frame_end <= 1'b0;
            sr <= '0;
            rb <= '0;
            bcnt <= '0;
            rd_v <= 1'b0;
            rd_src <= '0;
            cmd_strobe <= 1'b0;
            cmd_err <= 1'b0;
            r <= (NREG * DATA_W)'(R0_RST);
            pend <= '0;
            gcnt <= '0;
            major_mode <= OFF;
            state <= IDLE;
        end else begin
            spck_s <= SYNC'({spck_s, spck});
            ncs_s <= SYNC'({ncs_s, ncs});
            mosi_s <= SYNC'({mosi_s, mosi});
            spck_d <= spck_y;
            ncs_d <= ncs_y;
            frame_end <= ncs_rise;
            if (spck_rise && !ncs_y) begin
                sr <= {sr[CMD_W-2:0], mosi_y};
                if (bcnt != CW'(CMD_W + 1))
                    bcnt <= bcnt + 1'b1;
            end
            if (ncs_fall) begin
                bcnt <= '0;
                rb <= rd_v ? CMD_W'(r[rd_src]) << (CMD_W - DATA_W) : '0;
                rd_v <= 1'b0;
            end else if (spck_fall) begin
                rb <= {rb[CMD_W-2:0], 1'b0};
            end
            cmd_strobe <= ok;
            cmd_err <= frame_end && !ok;
            if (ok && op == OP_RD) begin
                rd_v <= 1'b1;
                rd_src <= idx;
            end
            for (int k = 1; k < NREG; k++)
                if (ok && op == OP_W'(k + 1))
                    r[k] <= dat;
            r[0] <= reg0_nx;
            major_mode <= mode_nx;
            pend <= pend_nx;
            gcnt <= gcnt_nx;
            state <= state_nx;
        end
    end
endmodule

// File: tb/tb_spi_conf_regs.sv
// tb_spi_conf_regs: directed SPI frames against spi_conf_regs, default guard plus a long-guard instance
module tb_spi_conf_regs;
    localparam int GL = 400;
    logic clk = 1'b0, nrst = 1'b0, spck = 1'b0, ncs = 1'b1, mosi = 1'b0;
    logic miso, busy, stb, err, miso_l, busy_l, stb_l, err_l;
    logic [31:0] regs, regs_l;
    logic [2:0] mm, mm_l;
    logic seen_l = 1'b0;
    int passes = 0, fails = 0, total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) if (mm_l == 3'b011) seen_l <= 1'b1;

    spi_conf_regs u_dut (
        .ck_1356meg(clk), .nrst(nrst), .spck(spck), .ncs(ncs), .mosi(mosi), .miso(miso),
        .regs(regs), .major_mode(mm), .mode_busy(busy), .cmd_strobe(stb), .cmd_err(err)
    );
    spi_conf_regs #(.GUARD(GL)) u_long (
        .ck_1356meg(clk), .nrst(nrst), .spck(spck), .ncs(ncs), .mosi(mosi), .miso(miso_l),
        .regs(regs_l), .major_mode(mm_l), .mode_busy(busy_l), .cmd_strobe(stb_l), .cmd_err(err_l)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic frame(input logic [31:0] w, input int n, output logic [31:0] rx,
                         output int lat, output logic s, output logic e);
        rx = '0;
        lat = 0;
        s = 1'b0;
        e = 1'b0;
        repeat (6) tick();
        ncs = 1'b0;
        repeat (4) tick();
        for (int i = n - 1; i >= 0; i--) begin
            mosi = w[i];
            repeat (4) tick();
            rx = {rx[30:0], miso};
            spck = 1'b1;
            repeat (4) tick();
            spck = 1'b0;
        end
        repeat (4) tick();
        ncs = 1'b1;
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            tick();
            if (stb || err) begin
                lat = c;
                s = stb;
                e = err;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rx;
        int lat, n, nb, ns;
        logic s, e;
        repeat (3) tick();
        chk("rst_regs", regs, 32'h0000_00E0);
        chk("rst_mode", 32'(mm), 32'h7);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_miso", 32'(miso), 0);
        chk("rst_stb", 32'(stb), 0);
        chk("rst_err", 32'(err), 0);
        nrst = 1'b1;
        repeat (6) tick();
        chk("rel_err", 32'(err), 0);

        frame(32'h10A5, 16, rx, lat, s, e);
        chk("wr0_lat", lat, 4);
        chk("wr0_stb", 32'(s), 1);
        chk("wr0_off", 32'(mm), 32'h7);
        chk("wr0_old", 32'(regs[7:0]), 32'hE0);
        n = 0;
        nb = 0;
        ns = 0;
        while (mm == 3'b111 && n < 40) begin
            nb += int'(busy);
            ns += int'(stb);
            tick();
            n++;
        end
        chk("wr0_offcyc", n, 8);
        chk("wr0_busycyc", nb, 8);
        chk("wr0_nstb", ns, 1);
        chk("wr0_mode", 32'(mm), 32'h5);
        chk("wr0_regs", regs, 32'h0000_00A5);
        chk("wr0_busy_end", 32'(busy), 0);

        frame(32'h2033, 16, rx, lat, s, e);
        chk("wr1_lat", lat, 4);
        chk("wr1_stb", 32'(s), 1);
        chk("wr1_regs", regs, 32'h0000_33A5);
        chk("wr1_mode", 32'(mm), 32'h5);
        chk("wr1_busy", 32'(busy), 0);

        frame(32'h2044, 15, rx, lat, s, e);
        chk("short_lat", lat, 4);
        chk("short_err", 32'(e), 1);
        chk("short_stb", 32'(s), 0);
        chk("short_regs", regs, 32'h0000_33A5);
        frame(32'h12044, 17, rx, lat, s, e);
        chk("long_err", 32'(e), 1);
        chk("long_regs", regs, 32'h0000_33A5);
        frame(32'h5011, 16, rx, lat, s, e);
        chk("badop_err", 32'(e), 1);
        chk("badop_regs", regs, 32'h0000_33A5);

        frame(32'h40AA, 16, rx, lat, s, e);
        chk("wr3_stb", 32'(s), 1);
        chk("wr3_regs", regs, 32'hAA00_33A5);

        frame(32'hF001, 16, rx, lat, s, e);
        chk("rd1_stb", 32'(s), 1);
        chk("rd1_idle_miso", rx, 0);
        frame(32'h0000, 16, rx, lat, s, e);
        chk("nop_stb", 32'(s), 1);
        chk("rd1_data", rx, 32'h3300);
        chk("nop_regs", regs, 32'hAA00_33A5);
        frame(32'hF003, 16, rx, lat, s, e);
        frame(32'h0000, 16, rx, lat, s, e);
        chk("rd3_data", rx, 32'hAA00);
        frame(32'h0000, 16, rx, lat, s, e);
        chk("rd_cleared", rx, 0);

        frame(32'h10BB, 16, rx, lat, s, e);
        chk("same_stb", 32'(s), 1);
        chk("same_reg0", 32'(regs[7:0]), 32'hBB);
        chk("same_mode", 32'(mm), 32'h5);
        chk("same_busy", 32'(busy), 0);

        frame(32'h1060, 16, rx, lat, s, e);
        chk("rep1_off", 32'(mm_l), 32'h7);
        frame(32'h1080, 16, rx, lat, s, e);
        chk("rep2_off", 32'(mm_l), 32'h7);
        chk("rep2_main_off", 32'(mm), 32'h7);
        n = 0;
        while (mm_l == 3'b111 && n < 1000) begin
            tick();
            n++;
        end
        chk("rep_offcyc", n, GL);
        chk("rep_mode", 32'(mm_l), 32'h4);
        chk("rep_reg0", 32'(regs_l[7:0]), 32'h80);
        chk("rep_no011", 32'(seen_l), 0);
        chk("main_mode4", 32'(mm), 32'h4);

        frame(32'h10C0, 16, rx, lat, s, e);
        chk("rg_off", 32'(mm), 32'h7);
        chk("rg_busy", 32'(busy), 1);
        repeat (3) tick();
        nrst = 1'b0;
        #1;
        chk("rg_mode", 32'(mm), 32'h7);
        chk("rg_busy0", 32'(busy), 0);
        chk("rg_regs", regs, 32'h0000_00E0);
        chk("rg_miso", 32'(miso), 0);
        repeat (2) tick();
        nrst = 1'b1;
        repeat (20) tick();
        chk("rg_drop_mode", 32'(mm), 32'h7);
        chk("rg_drop_busy", 32'(busy), 0);
        chk("rg_drop_regs", regs, 32'h0000_00E0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/spi_conf_regs.md
# spi_conf_regs

Parametrised successor to the top-level SPI configuration receiver. It oversamples the ARM's SPI lines (`spck`, `mosi`, `ncs`) in the system clock domain and decodes fixed-length command words into a bank of `NREG` configuration registers. It supports register readback on `miso` and reports malformed frames. Major-mode changes are applied glitch-free: the block forces an "everything off" window before a new mode takes over the coil drivers and SSP muxes.

## Interface
Parameters:
- `CMD_W`, 16: bits per SPI command word.
- `OP_W`, 4: opcode field width, taken from the top of the word.
- `DATA_W`, 8: register width, taken from the bottom of the word.
- `NREG`, 4: number of registers. Must satisfy 1 ≤ NREG ≤ 2^OP_W−2.
- `MODE_W`, 3: major-mode field width, located at reg0[DATA_W-1 -: MODE_W].
- `GUARD`, 8: number of off-cycles inserted on a mode change. Must be ≥ 1.
- `SYNC`, 2: synchroniser depth for `spck`, `ncs` and `mosi`.

Ports:
- `ck_1356meg`, in, 1: system clock. Everything is clocked on its rising edge.
- `nrst`, in, 1: asynchronous active-low reset.
- `spck`, in, 1: SPI clock, asynchronous to `ck_1356meg`.
- `ncs`, in, 1: SPI chip select, active low.
- `mosi`, in, 1: SPI data in; the MSB of each word arrives first.
- `miso`, out, 1: readback data.
- `regs`, out, NREG*DATA_W: register bank; reg k occupies bits [k*DATA_W +: DATA_W].
- `major_mode`, out, MODE_W: the applied mode. All-ones means everything off.
- `mode_busy`, out, 1: high while a guard window is active.
- `cmd_strobe`, out, 1: one-cycle pulse when a valid command is accepted.
- `cmd_err`, out, 1: one-cycle pulse when a frame is rejected.

## Operation
- **Reset values.** All flops are cleared asynchronously on `nrst` low. `regs` = 0 except the reg0 mode field, which is all ones. `major_mode` = all ones. `miso`, `mode_busy`, `cmd_strobe` and `cmd_err` = 0.
- **Synchronisation.** `spck`, `ncs` and `mosi` each pass through `SYNC` flops. Edges are detected on the synchronised signals.
- **Bit capture.** On a synced `spck` rising edge while synced `ncs` is low, `mosi` is shifted into a CMD_W shift register. A bit counter increments and saturates at CMD_W+1.
- **Frame start.** On a synced `ncs` falling edge, the bit counter clears.
- **Frame end.** On a synced `ncs` rising edge, the frame is evaluated:
  - Counter ≠ CMD_W: pulse `cmd_err`; no state changes.
  - op = 0: NOP; pulse `cmd_strobe`.
  - op = 1..NREG: write the data field to reg(op−1); pulse `cmd_strobe`.
  - op = all ones: read request. data[log2(NREG)-1:0] selects a register, which is latched as the read source. An index ≥ NREG pulses `cmd_err`; otherwise pulse `cmd_strobe`.
  - Any other op: pulse `cmd_err`.
- **Readback.** On a synced `ncs` falling edge, if a read source is latched, the readback shifter loads {reg[src], CMD_W−DATA_W zeros}.
  - `miso` presents the MSB, then advances one bit on each synced `spck` falling edge.
  - The read source clears after it has been used once.
  - With no read pending, `miso` = 0.
- **Mode FSM, states IDLE and GUARD.** Writes to registers other than reg0 go straight to `regs`.
  - IDLE, reg0 write with mode field equal to `major_mode`: reg0 is updated immediately.
  - IDLE, reg0 write with a different mode field: store it as pending, force `major_mode` to all ones, load the guard counter with GUARD, set `mode_busy`, and go to GUARD.
  - In GUARD, reg0 is still the old value until the new one is applied.
  - GUARD: the counter decrements each cycle. When it reaches 0, apply the pending value to reg0 and `major_mode`, clear `mode_busy`, and return to IDLE.
  - GUARD, another reg0 write: replace the pending value and reload the counter. If the new mode equals the mode already applied before GUARD, the off-window still completes.
  - A pending value whose mode is all ones is applied with no guard.
- **Reset mid-frame or mid-guard.** The partial frame is discarded, the pending value is lost, and the outputs return to their reset values.

## Timing
- Write latency: reg updated SYNC+2 cycles after the `ncs` pin rises. `cmd_strobe` and `cmd_err` pulse in that same cycle.
- Mode change: `major_mode` = all ones from write cycle+0 to +GUARD−1; new mode appears at write cycle + GUARD.
- SPI constraints: `spck` high and low each ≥ SYNC+1 clock periods. `ncs` setup and hold to `spck` ≥ SYNC+1 periods. `ncs` high ≥ SYNC+2 periods between frames.
- `miso` changes SYNC+1 cycles after a `spck` pin falling edge, so it is stable at the next `spck` rising edge.

## Test plan
- Reset, then frame 0x10A5 (16 bits) -> reg0 = 0xA5; `major_mode` all ones→101 after 8 off-cycles; `mode_busy` high for 8 cycles; one `cmd_strobe`.
- Frame 0x2033 -> reg1 = 0x33 at SYNC+2 cycles after `ncs` rises; `major_mode` untouched; no guard.
- 15-bit frame, then 17-bit frame -> two `cmd_err` pulses; `regs` unchanged.
- Read 0xF001, then a NOP frame -> `miso` shifts 0x33,0x00 MSB first (0011_0011_0000_0000).
- Write reg0 mode 011, then mode 100 three cycles later -> `major_mode` all ones for 3+8 cycles, then 100; 011 never appears.
- `nrst` low in the middle of a guard window -> `major_mode` all ones; `mode_busy` 0; pending value dropped.
